// File: rtl/avmm_mem_responder_pkg.sv
// rtl/avmm_mem_responder_pkg.sv - shared constants and types for the Avalon-MM memory responder
package avmm_pkg;

    localparam logic [31:0] ERR_READ_DATA = 32'hDEAD_0BAD;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;
    localparam int WAIT_MIN   = 0;
    localparam int WAIT_MAX   = 7;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } rd_slot_t;

endpackage

// File: rtl/avmm_mem_responder_if.sv
// rtl/avmm_mem_responder_if.sv - Avalon-MM style bus bundle between master and memory responder
interface avmm_mem_responder_if;

    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata, readdatavalid
    );

endinterface

// File: rtl/avmm_mem_responder_rd_pipe.sv
// rtl/avmm_mem_responder_rd_pipe.sv - fixed-latency read return shift register
module avmm_rd_pipe
    import avmm_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  rd_slot_t slot_i,
    output rd_slot_t slot_o
);

    rd_slot_t pipe_q [LAT];

    // One slot per cycle of latency, so any number of back-to-back reads stream through.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= slot_i;
            for (int i = 1; i < LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign slot_o = pipe_q[LAT-1];

endmodule

// File: rtl/avmm_mem_responder.sv
// rtl/avmm_mem_responder.sv - Avalon-MM memory responder with wait states, fixed read latency and error count
module avmm_mem_responder
    import avmm_pkg::*;
#(
    parameter int DEPTH_WORDS  = 256,
    parameter int READ_LATENCY = 2,
    parameter int WAIT_CYCLES  = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    avmm_mem_responder_if.slave     avmm_s,
    output logic [7:0]              err_count_o
);

    // Out-of-range parameters are pulled back into the supported window.
    localparam int RL = (READ_LATENCY < RD_LAT_MIN) ? RD_LAT_MIN :
                        (READ_LATENCY > RD_LAT_MAX) ? RD_LAT_MAX : READ_LATENCY;
    localparam int WC = (WAIT_CYCLES < WAIT_MIN) ? WAIT_MIN :
                        (WAIT_CYCLES > WAIT_MAX) ? WAIT_MAX : WAIT_CYCLES;
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [2:0]    wcnt_q, wcnt_d;
    logic [7:0]    err_q, err_d;
    logic          req;
    logic          stall;
    logic          accept;
    logic          in_range;
    logic          wr_en;
    logic [AW-1:0] idx;
    rd_slot_t      rd_in;
    rd_slot_t      rd_out;
    logic          unused_addr;

    assign req      = avmm_s.read | avmm_s.write;
    assign in_range = {2'b00, avmm_s.address[31:2]} < 32'(DEPTH_WORDS);
    assign idx      = avmm_s.address[AW+1:2];

    if (WC == 0) begin : g_no_wait
        assign stall = 1'b0;
    end else begin : g_wait
        assign stall = wcnt_q < 3'(WC);
    end

    assign avmm_s.waitrequest = !rst_n || (req && stall);
    assign accept             = rst_n && req && !stall;
    // A write wins over a simultaneous read, so the read half is simply discarded.
    assign wr_en              = accept && avmm_s.write && in_range;

    always_comb begin
        wcnt_d = '0;
        err_d  = err_q;
        rd_in  = '0;
        if (req && stall) begin
            wcnt_d = wcnt_q + 3'd1;
        end
        if (accept && (!in_range || (avmm_s.read && avmm_s.write)) && err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
        end
        if (accept && avmm_s.read && !avmm_s.write) begin
            rd_in.valid = 1'b1;
            rd_in.data  = in_range ? mem_q[idx] : ERR_READ_DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wcnt_q <= '0;
            err_q  <= '0;
        end else begin
            wcnt_q <= wcnt_d;
            err_q  <= err_d;
        end
    end

    // Storage is deliberately left out of reset so it survives a bus reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en && avmm_s.byteenable[i]) begin
                mem_q[idx][8*i +: 8] <= avmm_s.writedata[8*i +: 8];
            end
        end
    end

    avmm_rd_pipe #(.LAT(RL)) u_rd_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .slot_i (rd_in),
        .slot_o (rd_out)
    );

    assign avmm_s.readdatavalid = rst_n && rd_out.valid;
    assign avmm_s.readdata      = avmm_s.readdatavalid ? rd_out.data : 32'h0;
    assign err_count_o          = rst_n ? err_q : 8'h00;
    assign unused_addr          = ^avmm_s.address[1:0];

endmodule

// File: tb/tb_avmm_mem_responder.sv
// tb/tb_avmm_mem_responder.sv - self-checking bench for avmm_mem_responder
module tb_avmm_mem_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    avmm_mem_responder_if ifa ();
    avmm_mem_responder_if ifb ();
    logic [7:0] erra, errb;

    avmm_mem_responder #(.DEPTH_WORDS(256), .READ_LATENCY(2), .WAIT_CYCLES(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .avmm_s(ifa), .err_count_o(erra));
    avmm_mem_responder #(.DEPTH_WORDS(256), .READ_LATENCY(1), .WAIT_CYCLES(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .avmm_s(ifb), .err_count_o(errb));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference model of dut_a: word store, pending returns with due edge, error count.
    typedef struct {
        int          due;
        logic [31:0] data;
        bit          known;
    } ret_t;
    ret_t        q[$];
    logic [31:0] mem_m [int];
    int          merr = 0;

    initial begin
        int e = 0;
        forever begin
            bit hit;
            @(negedge clk);
            hit = (q.size() > 0) && (q[0].due == e);
            if (!rst_n) begin
                chk("a_rst_wait", {31'd0, ifa.waitrequest}, 32'd1);
                chk("a_rst_rdv", {31'd0, ifa.readdatavalid}, 32'd0);
                chk("a_rst_rdata", ifa.readdata, 32'd0);
                chk("a_rst_err", {24'd0, erra}, 32'd0);
            end else begin
                chk("a_wait", {31'd0, ifa.waitrequest}, 32'd0);
                chk("a_rdv", {31'd0, ifa.readdatavalid}, {31'd0, hit});
                if (hit && q[0].known) chk("a_rdata", ifa.readdata, q[0].data);
                if (!hit) chk("a_rdata_idle", ifa.readdata, 32'd0);
                chk("a_err", {24'd0, erra}, merr);
            end
            if (hit) void'(q.pop_front());
            @(posedge clk);
            e++;
            if (!rst_n) begin
                q.delete();
                merr = 0;
            end else if (ifa.read || ifa.write) begin
                int  w;
                bit  inr;
                w   = int'(ifa.address >> 2);
                inr = (ifa.address >> 2) < 256;
                if (!inr || (ifa.read && ifa.write)) merr = (merr < 255) ? merr + 1 : 255;
                if (ifa.write) begin
                    if (inr && (mem_m.exists(w) || ifa.byteenable == 4'hF)) begin
                        logic [31:0] v;
                        v = mem_m.exists(w) ? mem_m[w] : 32'h0;
                        for (int i = 0; i < 4; i++)
                            if (ifa.byteenable[i]) v[8*i +: 8] = ifa.writedata[8*i +: 8];
                        mem_m[w] = v;
                    end
                end else begin
                    ret_t r;
                    r.due   = e + 2 - 1;
                    r.known = !inr || mem_m.exists(w);
                    r.data  = !inr ? 32'hDEAD_0BAD : (mem_m.exists(w) ? mem_m[w] : 32'h0);
                    q.push_back(r);
                end
            end
        end
    end

    task automatic idle_a();
        ifa.read = 0; ifa.write = 0; ifa.address = 0; ifa.writedata = 0; ifa.byteenable = 0;
    endtask

    task automatic drv_a(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be);
        ifa.read = rd; ifa.write = wr; ifa.address = a; ifa.writedata = d; ifa.byteenable = be;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_a(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        drv_a(0, 1, a, d, be);
        idle_a();
    endtask

    task automatic rd_lit(input string nm, input logic [31:0] a, input logic [31:0] exp);
        int          lat = 0;
        logic [31:0] got = 32'h0;
        drv_a(1, 0, a, 32'h0, 4'h0);
        idle_a();
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (ifa.readdatavalid) begin
                lat = k;
                got = ifa.readdata;
                break;
            end
        end
        chk({nm, "_lat"}, lat, 32'd2);
        chk({nm, "_data"}, got, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_b();
        ifb.read = 0; ifb.write = 0; ifb.address = 0; ifb.writedata = 0; ifb.byteenable = 0;
    endtask

    task automatic hold_b(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, output int stalls);
        ifb.read = rd; ifb.write = wr; ifb.address = a; ifb.writedata = d; ifb.byteenable = be;
        stalls = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!ifb.waitrequest) break;
            stalls++;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    logic [31:0] got4 [4];

    initial begin
        int n, first, last, st;
        idle_a();
        idle_b();
        repeat (3) @(posedge clk);
        #1;
        chk("b_rst_wait", {31'd0, ifb.waitrequest}, 32'd1);
        rst_n = 1;
        @(posedge clk);
        #1;

        // single write then read
        wr_a(32'h20, 32'hDEADBEEF, 4'hF);
        rd_lit("rd20", 32'h20, 32'hDEADBEEF);

        // back-to-back reads
        wr_a(32'h24, 32'hCAFEBABE, 4'hF);
        wr_a(32'h28, 32'h12345678, 4'hF);
        wr_a(32'h2C, 32'hABCDEF01, 4'hF);
        n = 0; first = -1; last = -1;
        fork
            begin
                for (int i = 0; i < 4; i++) drv_a(1, 0, 32'h20 + 32'(4 * i), 32'h0, 4'h0);
                idle_a();
            end
            begin
                for (int k = 0; k < 14; k++) begin
                    @(negedge clk);
                    if (ifa.readdatavalid) begin
                        if (n < 4) got4[n] = ifa.readdata;
                        if (first < 0) first = k;
                        last = k;
                        n++;
                    end
                end
            end
        join
        chk("b2b_count", n, 32'd4);
        chk("b2b_span", last - first, 32'd3);
        chk("b2b_d0", got4[0], 32'hDEADBEEF);
        chk("b2b_d1", got4[1], 32'hCAFEBABE);
        chk("b2b_d2", got4[2], 32'h12345678);
        chk("b2b_d3", got4[3], 32'hABCDEF01);
        @(posedge clk);
        #1;

        // byte lanes and empty byteenable
        wr_a(32'h40, 32'h11223344, 4'hF);
        wr_a(32'h40, 32'hAABBCCDD, 4'b0101);
        rd_lit("be0101", 32'h40, 32'h11BB33DD);
        wr_a(32'h44, 32'h55667788, 4'hF);
        wr_a(32'h44, 32'h00000000, 4'h0);
        rd_lit("be0000", 32'h44, 32'h55667788);

        // range and protocol errors
        chk("err_zero", {24'd0, erra}, 32'd0);
        rd_lit("oor_rd", 32'h400, 32'hDEAD0BAD);
        chk("err_oor_rd", {24'd0, erra}, 32'd1);
        drv_a(1, 1, 32'h48, 32'h0BADF00D, 4'hF);
        idle_a();
        chk("err_rw", {24'd0, erra}, 32'd2);
        rd_lit("rw_wrote", 32'h48, 32'h0BADF00D);
        wr_a(32'h0, 32'h01010101, 4'hF);
        wr_a(32'h400, 32'hFFFFFFFF, 4'hF);
        chk("err_oor_wr", {24'd0, erra}, 32'd3);
        rd_lit("oor_no_alias", 32'h0, 32'h01010101);

        // saturation
        for (int i = 0; i < 260; i++) drv_a(1, 0, 32'h400, 32'h0, 4'h0);
        idle_a();
        repeat (4) @(posedge clk);
        #1;
        chk("err_sat", {24'd0, erra}, 32'hFF);

        // reset with reads in flight
        drv_a(1, 0, 32'h20, 32'h0, 4'h0);
        drv_a(1, 0, 32'h24, 32'h0, 4'h0);
        idle_a();
        rst_n = 0;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ifa.readdatavalid) n++;
            @(posedge clk);
            #1;
            if (k == 1) rst_n = 1;
        end
        chk("rst_no_rdv", n, 32'd0);
        chk("rst_err", {24'd0, erra}, 32'd0);
        rd_lit("rst_keep", 32'h20, 32'hDEADBEEF);

        // wait states on dut_b
        chk("b_idle_wait", {31'd0, ifb.waitrequest}, 32'd0);
        hold_b(0, 1, 32'h10, 32'h01020304, 4'hF, st);
        chk("b_wr_stalls", st, 32'd3);
        hold_b(1, 0, 32'h10, 32'h0, 4'h0, st);
        idle_b();
        chk("b_rd_stalls", st, 32'd3);
        @(negedge clk);
        chk("b_rdv", {31'd0, ifb.readdatavalid}, 32'd1);
        chk("b_rdata", ifb.readdata, 32'h01020304);
        @(negedge clk);
        chk("b_rdv_once", {31'd0, ifb.readdatavalid}, 32'd0);
        chk("b_err", {24'd0, errb}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/avmm_mem_responder.md
AVMM_MEM_RESPONDER -- requirements
Module: avmm_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit memory words (power of two).
REQ-002 The block SHALL have parameter READ_LATENCY, default 2, meaning cycles from read acceptance to readdatavalid (legal 1..4).
REQ-003 The block SHALL have parameter WAIT_CYCLES, default 0, meaning waitrequest cycles inserted before each request is accepted (legal 0..7).
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 address  input  32  byte address from the master; bits [1:0] ignored.
REQ-007 read  input  1  read request.
REQ-008 write  input  1  write request.
REQ-009 writedata  input  32  write data.
REQ-010 byteenable  input  4  byte-lane write enables; lane i = writedata[8i+7:8i].
REQ-011 waitrequest  output  1  stall; the request is held by the master while high.
REQ-012 readdata  output  32  read data, valid only when readdatavalid is high.
REQ-013 readdatavalid  output  1  one-cycle strobe per accepted read.
REQ-014 err_count  output  8  saturating count of protocol/range errors.

Function
REQ-015 Request = read|write; accepted on the edge where request is high and waitrequest is low.
REQ-016 waitrequest = request && (wcnt < WAIT_CYCLES), combinational; 0 when no request; 0 always when WAIT_CYCLES=0.
REQ-017 wcnt (3-bit) SHALL increment each cycle a request is stalled, and clear to 0 on acceptance or when the request drops.
REQ-018 Word index = address[31:2]; in range iff index < DEPTH_WORDS.
REQ-019 An accepted in-range write SHALL update only the byteenable-selected lanes at the acceptance edge; byteenable=0 writes nothing.
REQ-020 An accepted read samples memory at acceptance; a write accepted in an earlier cycle is visible, and no same-cycle hazard exists because a single request is accepted per cycle.
REQ-021 An accepted read at edge T SHALL give readdatavalid=1 for exactly the cycle following edge T+READ_LATENCY-1 (i.e. READ_LATENCY cycles after the request cycle), with readdata = sampled word.
REQ-022 Back-to-back accepted reads (one per cycle) SHALL return back-to-back, in order, with no limit on outstanding reads (pipeline depth = READ_LATENCY).
REQ-023 Out-of-range write SHALL be dropped and increment err_count; out-of-range read SHALL return 32'hDEAD_0BAD with normal latency and increment err_count.
REQ-024 read && write both high SHALL be treated as a write only (read discarded, no readdatavalid) and increment err_count.
REQ-025 err_count SHALL saturate at 8'hFF; at most one increment per accepted request.
REQ-026 readdata SHALL hold 0 whenever readdatavalid is 0.

Reset
REQ-027 While rst_n=0: readdatavalid=0, readdata=0, err_count=0, wcnt=0, all latency-pipeline valids cleared, waitrequest=1.
REQ-028 Reset mid-operation SHALL drop all pending reads (no readdatavalid after reset) and SHALL abort any stalled request without a write.
REQ-029 Memory contents SHALL NOT be reset; contents are undefined until written.

Structure
REQ-030 Package avmm_pkg SHALL hold ERR_READ_DATA (32'hDEAD_0BAD), the legal-range constants for READ_LATENCY/WAIT_CYCLES, and the rd_slot_t struct {valid, data[31:0]}.
REQ-031 Sub-module avmm_rd_pipe (a READ_LATENCY-deep shift register of rd_slot_t) SHALL implement the read return path; memory, stall counter and error logic SHALL reside in the top.

Verification
REQ-032 Write 0x20 <- 0xDEADBEEF (be=4'hF), then read 0x20 with READ_LATENCY=2, WAIT_CYCLES=0 -> readdatavalid exactly 2 cycles after the read cycle, readdata=0xDEADBEEF.
REQ-033 Four back-to-back reads 0x20..0x2C of preloaded 0xDEADBEEF, 0xCAFEBABE, 0x12345678, 0xABCDEF01 -> four consecutive readdatavalid cycles, data in order.
REQ-034 WAIT_CYCLES=3, write held high -> waitrequest high 3 cycles, write lands on the 4th edge; the next request also stalls 3 cycles.
REQ-035 Write 0x11223344 to 0x40, then be=4'b0101 with 0xAABBCCDD -> read returns 0x11BB33DD.
REQ-036 Read 0x400 (DEPTH_WORDS=256) -> 0xDEAD0BAD with normal latency, err_count=1; read&write together -> write only, err_count=2.
REQ-037 Reset asserted one cycle after two accepted reads -> no readdatavalid afterwards; err_count=0; data previously written at 0x20 still readable after reset.
